capture_thresh_loader: RTL and testbench

Sequences per-channel trigger-threshold writes into the capture block's threshold RAM in the `user_clk` domain. Software writes one 32-bit command word through the capture load-threshold software register. This block decodes that word, detects command edges, and waits for the datapath's write-permission handshake. It then issues either a single-channel write or a full clear sweep. It sits between the register's `user_data_out` and the threshold RAM write port.

---
 rtl/capture_thresh_pkg.sv | 23 ++
 rtl/capture_cmd_edge.sv | 34 +++
 rtl/capture_thresh_loader.sv | 147 ++++++++++++++
 tb/tb_capture_thresh_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_thresh_pkg.sv
// Shared definitions for the capture threshold loader: FSM state encoding,
// command-word field positions and the clear-sweep fill value.
package capture_thresh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    localparam int LOAD_BIT  = 31;
    localparam int CLEAR_BIT = 30;
    localparam int ACK_BIT   = 29;
    localparam int CHAN_LSB  = 16;

    // Threshold value that disables triggering on a channel.
    localparam logic [15:0] THRESH_INIT_DEFAULT = 16'h7FFF;

    // Command bits come out of reset as ones so a bit held high through
    // reset is never seen as a rising edge.
    localparam logic [31:0] WORD_RST = 32'hE000_0000;

endpackage

// File: rtl/capture_cmd_edge.sv
// Registers the software command word and detects 0->1 edges on the
// load, clear_all and err_ack bits against a one-cycle-delayed history.
module capture_cmd_edge
    import capture_thresh_pkg::*;
(
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic [31:0] reg_word,
    output logic [31:0] r_word_o,
    output logic        load_edge_o,
    output logic        clear_edge_o,
    output logic        ack_edge_o
);

    logic [31:0] word_q;
    logic [2:0]  hist_q;   // {load, clear, ack} from the previous cycle

    // Capture the command word and keep one cycle of command-bit history.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            word_q <= WORD_RST;
            hist_q <= 3'b111;
        end else begin
            word_q <= reg_word;
            hist_q <= {word_q[LOAD_BIT], word_q[CLEAR_BIT], word_q[ACK_BIT]};
        end
    end

    assign r_word_o     = word_q;
    assign load_edge_o  = word_q[LOAD_BIT]  & ~hist_q[2];
    assign clear_edge_o = word_q[CLEAR_BIT] & ~hist_q[1];
    assign ack_edge_o   = word_q[ACK_BIT]   & ~hist_q[0];

endmodule

// File: rtl/capture_thresh_loader.sv
// Sequences single-channel threshold loads and full clear sweeps into the
// capture threshold RAM, gated by the datapath write-permission handshake.
module capture_thresh_loader
    import capture_thresh_pkg::*;
#(
    parameter int          N_CHAN_BITS = 8,
    parameter int          THRESH_W    = 16,
    parameter logic [15:0] THRESH_INIT = THRESH_INIT_DEFAULT
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            reg_word,
    input  logic                   thr_wr_ok,
    output logic                   thr_we,
    output logic [N_CHAN_BITS-1:0] thr_addr,
    output logic [THRESH_W-1:0]    thr_data,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [15:0]            load_count,
    output logic                   err_overrun
);

    localparam logic [N_CHAN_BITS-1:0] ADDR_ZERO = {N_CHAN_BITS{1'b0}};
    localparam logic [N_CHAN_BITS-1:0] ADDR_LAST = {N_CHAN_BITS{1'b1}};
    localparam logic [N_CHAN_BITS-1:0] ADDR_ONE  = {{(N_CHAN_BITS-1){1'b0}}, 1'b1};

    logic [31:0]            r_word_s;
    logic                   load_edge_s;
    logic                   clear_edge_s;
    logic                   ack_edge_s;
    logic                   unused_word_s;

    state_e                 state_q,  state_d;
    logic [N_CHAN_BITS-1:0] addr_q,   addr_d;
    logic [THRESH_W-1:0]    data_q,   data_d;
    logic [15:0]            count_q,  count_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;
    logic                   we_s;
    logic                   overrun_s;

    capture_cmd_edge u_cmd_edge (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .reg_word     (reg_word),
        .r_word_o     (r_word_s),
        .load_edge_o  (load_edge_s),
        .clear_edge_o (clear_edge_s),
        .ack_edge_o   (ack_edge_s)
    );

    // Only the channel/threshold fields are consumed here; fold the rest away.
    assign unused_word_s = ^r_word_s;

    // Next-state, write strobe and overrun detection.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;
        done_d    = 1'b0;
        we_s      = 1'b0;
        overrun_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_edge_s) begin
                    // Clear wins a collision; a simultaneous load is dropped.
                    addr_d    = ADDR_ZERO;
                    data_d    = THRESH_INIT[THRESH_W-1:0];
                    state_d   = ST_SWEEP;
                    overrun_s = load_edge_s;
                end else if (load_edge_s) begin
                    addr_d  = r_word_s[CHAN_LSB +: N_CHAN_BITS];
                    data_d  = r_word_s[THRESH_W-1:0];
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                we_s      = thr_wr_ok;
                overrun_s = load_edge_s | clear_edge_s;
                if (thr_wr_ok) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SWEEP: begin
                we_s      = thr_wr_ok;
                overrun_s = load_edge_s | clear_edge_s;
                if (thr_wr_ok) begin
                    if (addr_q == ADDR_LAST) begin
                        // Final write: address stays at all-ones.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A same-cycle overrun beats the acknowledge.
        if (overrun_s) begin
            err_d = 1'b1;
        end else if (ack_edge_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_ZERO;
            data_q  <= {THRESH_W{1'b0}};
            count_q <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign thr_we      = we_s;
    assign thr_addr    = addr_q;
    assign thr_data    = data_q;
    assign busy        = (state_q != ST_IDLE);
    assign sweep_done  = done_q;
    assign load_count  = count_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_capture_thresh_loader.sv
// Directed self-checking bench for capture_thresh_loader (N_CHAN_BITS=8).
module tb_capture_thresh_loader;

    logic        user_clk;
    logic        user_rst;
    logic [31:0] reg_word;
    logic        thr_wr_ok;
    logic        thr_we;
    logic [7:0]  thr_addr;
    logic [15:0] thr_data;
    logic        busy;
    logic        sweep_done;
    logic [15:0] load_count;
    logic        err_overrun;

    int n_pass  = 0;
    int n_total = 0;

    capture_thresh_loader #(
        .N_CHAN_BITS (8),
        .THRESH_W    (16),
        .THRESH_INIT (16'h7FFF)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .reg_word    (reg_word),
        .thr_wr_ok   (thr_wr_ok),
        .thr_we      (thr_we),
        .thr_addr    (thr_addr),
        .thr_data    (thr_data),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .load_count  (load_count),
        .err_overrun (err_overrun)
    );

    // 100 MHz clock.
    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Let a sweep run from address 0; tally writes and irregularities.
    task automatic run_sweep(input bit toggle, output int writes, output int addr_bad,
                             output int we_bad);
        int cyc;
        writes   = 0;
        addr_bad = 0;
        we_bad   = 0;
        cyc      = 0;
        while (writes < 256 && cyc < 2000) begin
            thr_wr_ok = toggle ? cyc[0] : 1'b1;
            #1;
            if (thr_we !== thr_wr_ok) we_bad++;
            if (thr_we === 1'b1) begin
                if (thr_addr !== writes[7:0] || thr_data !== 16'h7FFF) addr_bad++;
                writes++;
            end
            step();
            cyc++;
        end
    endtask

    initial begin
        int w, ab, wb, bad;

        // ---------------- reset ----------------
        user_rst  = 1'b1;
        reg_word  = 32'h0;
        thr_wr_ok = 1'b1;
        repeat (3) step();
        chk("rst_we",    {31'd0, thr_we},      32'd0);
        chk("rst_addr",  {24'd0, thr_addr},    32'd0);
        chk("rst_data",  {16'd0, thr_data},    32'd0);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_done",  {31'd0, sweep_done},  32'd0);
        chk("rst_cnt",   {16'd0, load_count},  32'd0);
        chk("rst_err",   {31'd0, err_overrun}, 32'd0);
        user_rst = 1'b0;
        step();

        // ---------------- single load ----------------
        reg_word = 32'h8005_1234;
        step();                                   // edge k: word registered
        chk("ld_we_k1",  {31'd0, thr_we}, 32'd0);
        chk("ld_busy_k1", {31'd0, busy},  32'd0);
        step();                                   // now in LOAD
        chk("ld_we",     {31'd0, thr_we},   32'd1);
        chk("ld_addr",   {24'd0, thr_addr}, 32'd5);
        chk("ld_data",   {16'd0, thr_data}, 32'h1234);
        step();
        chk("ld_busy_after", {31'd0, busy},       32'd0);
        chk("ld_cnt",        {16'd0, load_count}, 32'd1);
        chk("ld_we_after",   {31'd0, thr_we},     32'd0);

        // ---------------- stalled load ----------------
        reg_word = 32'h0;
        step();
        thr_wr_ok = 1'b0;
        reg_word  = 32'h8007_ABCD;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b1 || thr_we !== 1'b0) bad++;
            step();
        end
        chk("stall_hold", bad, 32'd0);
        chk("stall_cnt",  {16'd0, load_count}, 32'd1);
        thr_wr_ok = 1'b1;
        #1;
        chk("stall_we",   {31'd0, thr_we},   32'd1);
        chk("stall_addr", {24'd0, thr_addr}, 32'd7);
        chk("stall_data", {16'd0, thr_data}, 32'hABCD);
        step();
        chk("stall_cnt2", {16'd0, load_count}, 32'd2);
        chk("stall_busy", {31'd0, busy},       32'd0);

        // ---------------- clear sweep, 50% wr_ok ----------------
        reg_word = 32'h4000_0000;
        step();
        step();
        chk("sw_busy",  {31'd0, busy},     32'd1);
        chk("sw_addr0", {24'd0, thr_addr}, 32'd0);
        run_sweep(1'b1, w, ab, wb);
        chk("sw_writes",  w,  32'd256);
        chk("sw_order",   ab, 32'd0);
        chk("sw_we_gate", wb, 32'd0);
        chk("sw_done",    {31'd0, sweep_done}, 32'd1);
        chk("sw_idle",    {31'd0, busy},       32'd0);
        chk("sw_addr_ff", {24'd0, thr_addr},   32'hFF);
        chk("sw_err",     {31'd0, err_overrun}, 32'd0);
        step();
        chk("sw_done_pulse", {31'd0, sweep_done}, 32'd0);

        // ---------------- overrun ----------------
        thr_wr_ok = 1'b0;
        reg_word  = 32'h0;
        step();
        reg_word = 32'h4000_0000;
        step();
        step();
        reg_word = 32'hC002_5555;                 // load edge while sweeping
        step();
        step();
        chk("ovr_err",  {31'd0, err_overrun}, 32'd1);
        chk("ovr_addr", {24'd0, thr_addr},    32'd0);
        run_sweep(1'b0, w, ab, wb);
        chk("ovr_writes", w,  32'd256);
        chk("ovr_order",  ab, 32'd0);
        chk("ovr_cnt",    {16'd0, load_count}, 32'd2);
        chk("ovr_err_hold", {31'd0, err_overrun}, 32'd1);
        reg_word = 32'h2000_0000;                 // acknowledge
        step();
        step();
        chk("ack_err", {31'd0, err_overrun}, 32'd0);
        chk("ack_busy", {31'd0, busy},       32'd0);

        // ---------------- reset mid-sweep ----------------
        reg_word = 32'h0;
        step();
        thr_wr_ok = 1'b1;
        reg_word  = 32'h4000_0000;
        step();
        step();
        repeat (100) step();
        chk("rs_addr100", {24'd0, thr_addr}, 32'd100);
        user_rst = 1'b1;
        reg_word = 32'h8000_0000;
        step();
        chk("rs_we",   {31'd0, thr_we},      32'd0);
        chk("rs_addr", {24'd0, thr_addr},    32'd0);
        chk("rs_data", {16'd0, thr_data},    32'd0);
        chk("rs_busy", {31'd0, busy},        32'd0);
        chk("rs_done", {31'd0, sweep_done},  32'd0);
        chk("rs_cnt",  {16'd0, load_count},  32'd0);
        chk("rs_err",  {31'd0, err_overrun}, 32'd0);
        step();
        step();
        user_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (thr_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rs_held_high", bad, 32'd0);

        // ---------------- collision ----------------
        reg_word = 32'h0;
        step();
        reg_word = 32'hC009_1111;
        step();
        step();
        chk("col_busy", {31'd0, busy},        32'd1);
        chk("col_err",  {31'd0, err_overrun}, 32'd1);
        chk("col_data", {16'd0, thr_data},    32'h7FFF);
        chk("col_addr", {24'd0, thr_addr},    32'd0);
        run_sweep(1'b0, w, ab, wb);
        chk("col_writes", w,  32'd256);
        chk("col_order",  ab, 32'd0);
        chk("col_done",   {31'd0, sweep_done}, 32'd1);
        chk("col_cnt",    {16'd0, load_count}, 32'd0);
        step();
        chk("col_idle",   {31'd0, busy},       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
